// File: rtl/print_sequencer_pkg.sv
// Shared definitions for the print sequencer and the board renderer.
package print_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        ARM     = 3'd2,
        STEP    = 3'd3,
        SAMPLE  = 3'd4,
        SEND    = 3'd5,
        WAIT_TX = 3'd6
    } seq_state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Character counter width covers the largest watchdog limit (1023).
    localparam int CHAR_CNT_W  = 10;
    localparam int PRIME_CNT_W = 8;

endpackage

// File: rtl/print_sequencer.sv
// Print sequencer: steps the board renderer one character at a time and
// forwards each character to the UART, with request coalescing and a
// per-frame character watchdog.
module print_sequencer
    import print_sequencer_pkg::*;
#(
    parameter int PRIME_STEPS = 2,
    parameter int MAX_CHARS   = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    output logic       r_start,
    output logic       r_next,
    input  logic [7:0] r_char,
    input  logic       r_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    localparam logic [CHAR_CNT_W-1:0]  MAX_CNT   = CHAR_CNT_W'(MAX_CHARS);
    localparam logic [PRIME_CNT_W-1:0] PRIME_CNT = PRIME_CNT_W'(PRIME_STEPS);

    seq_state_t state_q, state_d;
    logic                   pending_q, pending_d;
    logic                   err_q, err_d;
    logic [CHAR_CNT_W-1:0]  char_cnt_q, char_cnt_d;
    logic [PRIME_CNT_W-1:0] prime_q, prime_d;
    logic                   tx_idle_q, tx_idle_d;   // one quiet WAIT_TX cycle seen
    logic                   seen_busy_q, seen_busy_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   r_start_q, r_start_d;
    logic                   r_next_q, r_next_d;
    logic                   tx_start_q, tx_start_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;
    logic                   frame_ok, send_ok;

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            char_cnt_q   <= '0;
            prime_q      <= '0;
            tx_idle_q    <= 1'b0;
            seen_busy_q  <= 1'b0;
            tx_data_q    <= 8'h00;
            r_start_q    <= 1'b0;
            r_next_q     <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
            char_cnt_q   <= char_cnt_d;
            prime_q      <= prime_d;
            tx_idle_q    <= tx_idle_d;
            seen_busy_q  <= seen_busy_d;
            tx_data_q    <= tx_data_d;
            r_start_q    <= r_start_d;
            r_next_q     <= r_next_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic plus the per-frame counters and watchdog.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        err_d       = err_q;
        char_cnt_d  = char_cnt_q;
        prime_d     = prime_q;
        tx_idle_d   = tx_idle_q;
        seen_busy_d = seen_busy_q;
        tx_data_d   = tx_data_q;
        frame_ok    = 1'b0;
        send_ok     = 1'b0;

        // Requests during a frame collapse into a single follow-up frame.
        if (req && state_q != IDLE) pending_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    state_d    = START;
                    pending_d  = 1'b0;
                    err_d      = 1'b0;
                    char_cnt_d = '0;
                    prime_d    = PRIME_CNT;
                end
            end
            START: state_d = ARM;
            ARM: begin
                if (!r_done) state_d = STEP;
            end
            STEP: state_d = SAMPLE;
            SAMPLE: begin
                if (prime_q != '0) begin
                    // Renderer output still lags; drop it unconditionally.
                    prime_d = prime_q - PRIME_CNT_W'(1);
                    state_d = STEP;
                end else if (r_done) begin
                    frame_ok = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tx_data_d = r_char;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (char_cnt_q >= MAX_CNT) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (!tx_busy) begin
                    send_ok     = 1'b1;
                    if (char_cnt_q != '1) char_cnt_d = char_cnt_q + CHAR_CNT_W'(1);
                    tx_idle_d   = 1'b0;
                    seen_busy_d = 1'b0;
                    state_d     = WAIT_TX;
                end
            end
            WAIT_TX: begin
                // Either a full busy pulse, or two quiet cycles from a UART
                // too fast to ever show busy.
                if (tx_busy) begin
                    seen_busy_d = 1'b1;
                end else if (seen_busy_q || tx_idle_q) begin
                    state_d = STEP;
                end else begin
                    tx_idle_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs decoded from the state being entered.
    always_comb begin
        r_start_d    = (state_d == START);
        r_next_d     = (state_d == STEP);
        tx_start_d   = send_ok;
        busy_d       = (state_d != IDLE);
        frame_done_d = frame_ok;
    end

    assign r_start    = r_start_q;
    assign r_next     = r_next_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_print_sequencer.sv
// Self-checking bench for print_sequencer: renderer and UART models,
// a frame-level byte scoreboard, and directed scenarios.
module tb_print_sequencer;

    localparam int P_PRIME = 2;
    localparam int P_MAX   = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] r_char = 8'h00;
    logic       r_done = 1'b1;
    logic       tx_busy = 1'b0;
    logic       r_start, r_next, tx_start, busy, frame_done, err;
    logic [7:0] tx_data;

    print_sequencer #(.PRIME_STEPS(P_PRIME), .MAX_CHARS(P_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .r_start(r_start), .r_next(r_next), .r_char(r_char), .r_done(r_done),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Renderer configuration
    logic [7:0] rstr [0:7];
    int  rlen = 0, lag_done = 0, arm_delay = 3;
    bit  never_done = 0, fast = 0;

    function automatic logic [7:0] char_at(input int i);
        if (i < rlen) return rstr[i];
        return 8'h30 + 8'(i);
    endfunction

    // Renderer model: done falls arm_delay cycles after start; each advance
    // yields the next character, reporting stale done during the lag window.
    int pos = 0, arm_cnt = 0;
    always @(posedge clk) begin
        if (r_start) begin
            pos <= 0; arm_cnt <= arm_delay; r_done <= 1'b1;
        end else if (arm_cnt != 0) begin
            arm_cnt <= arm_cnt - 1;
            if (arm_cnt == 1) r_done <= 1'b0;
        end else if (r_next) begin
            if (!never_done && pos >= rlen) r_done <= 1'b1;
            else begin
                r_char <= char_at(pos);
                r_done <= (pos < lag_done);
                pos    <= pos + 1;
            end
        end
    end

    // UART model: 10 busy cycles per byte, or never busy when fast.
    int ucnt = 0;
    always @(posedge clk) begin
        if (tx_start && !fast) begin
            tx_busy <= 1'b1; ucnt <= 10;
        end else if (ucnt > 1) ucnt <= ucnt - 1;
        else if (ucnt == 1) begin ucnt <= 0; tx_busy <= 1'b0; end
    end

    int n_checks = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: bytes a frame must emit, derived from the renderer string,
    // the discarded leading characters and the watchdog limit.
    logic [7:0] exp_q [$];
    logic [7:0] tx_log [$];
    bit  exp_err = 0, err_seen = 0, gap_armed = 0;
    int  n_rs = 0, n_tx = 0, n_fd = 0, n_gap = 0;
    int  fd_cyc = -100, tx_cyc = 0, rs_gap = 0;

    task automatic model_frame();
        int avail, nsend;
        exp_q.delete();
        avail   = never_done ? 1000 : rlen;
        nsend   = avail - P_PRIME;
        exp_err = (nsend > P_MAX);
        if (exp_err) nsend = P_MAX;
        for (int i = 0; i < nsend; i++) exp_q.push_back(char_at(P_PRIME + i));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("start_next_exclusive", {31'd0, r_start & r_next}, 32'd0);
            if (r_start) begin
                n_rs++; rs_gap = cyc - fd_cyc; model_frame();
            end
            if (tx_start) begin
                chk("tx_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                tx_log.push_back(tx_data);
                n_tx++; tx_cyc = cyc; gap_armed = fast;
            end
            if (r_next && gap_armed) begin
                chk("fast_next_gap", cyc - tx_cyc, 32'd2);
                gap_armed = 0; n_gap++;
            end
            if (frame_done) begin
                chk("fd_all_sent", exp_q.size(), 32'd0);
                chk("fd_not_watchdog", {31'd0, exp_err}, 32'd0);
                n_fd++; fd_cyc = cyc;
            end
            if (err && !err_seen) begin
                chk("wd_all_sent", exp_q.size(), 32'd0);
                chk("wd_expected", {31'd0, exp_err}, 32'd1);
            end
            err_seen = err;
        end
    end

    function automatic logic [7:0] log_at(input int k);
        if (k < tx_log.size()) return tx_log[k];
        return 8'h00;
    endfunction

    task automatic set_frame(input string s, input int lag, input bit nd);
        for (int i = 0; i < s.len() && i < 8; i++) rstr[i] = s[i];
        rlen = s.len(); lag_done = lag; never_done = nd;
    endtask

    task automatic pulse_req();
        @(negedge clk) req = 1'b1;
        @(negedge clk) req = 1'b0;
    endtask

    task automatic wait_fd(input int target, input string nm);
        int k = 0;
        while (n_fd < target && k < 2000) begin @(negedge clk); k++; end
        chk(nm, {31'd0, n_fd >= target}, 32'd1);
    endtask

    task automatic wait_tx(input int target, input string nm);
        int k = 0;
        while (n_tx < target && k < 2000) begin @(negedge clk); k++; end
        chk(nm, {31'd0, n_tx >= target}, 32'd1);
    endtask

    task automatic wait_err(input string nm);
        int k = 0;
        while (!err && k < 2000) begin @(negedge clk); k++; end
        chk(nm, {31'd0, err}, 32'd1);
    endtask

    int b, f0, t0, g0, r0;

    initial begin
        set_frame("xyAB", 2, 0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {18'd0, r_start, r_next, tx_start, busy, frame_done, err, tx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame: leading "xy" discarded despite stale done.
        b = tx_log.size(); f0 = n_fd;
        pulse_req();
        wait_fd(f0 + 1, "t1_frame_done_seen");
        repeat (2) @(negedge clk);
        chk("t1_tx_count", tx_log.size() - b, 32'd2);
        chk("t1_byte0", {24'd0, log_at(b)}, 32'h41);
        chk("t1_byte1", {24'd0, log_at(b + 1)}, 32'h42);
        chk("t1_busy_low", {31'd0, busy}, 32'd0);
        chk("t1_err_low", {31'd0, err}, 32'd0);
        chk("t1_one_fd", n_fd - f0, 32'd1);

        // Coalescing: three requests mid-frame give one extra frame.
        set_frame("xyC", 2, 0);
        b = tx_log.size(); f0 = n_fd; r0 = n_rs;
        pulse_req();
        repeat (3) @(negedge clk);
        chk("t2_busy_during", {31'd0, busy}, 32'd1);
        repeat (3) begin pulse_req(); @(negedge clk); end
        wait_fd(f0 + 2, "t2_two_frames_seen");
        repeat (30) @(negedge clk);
        chk("t2_rstart_count", n_rs - r0, 32'd2);
        chk("t2_back_to_back", rs_gap, 32'd1);
        chk("t2_fd_count", n_fd - f0, 32'd2);
        chk("t2_byte0", {24'd0, log_at(b)}, 32'h43);
        chk("t2_byte1", {24'd0, log_at(b + 1)}, 32'h43);

        // Watchdog: renderer never finishes.
        set_frame("xy", 2, 1);
        b = tx_log.size(); f0 = n_fd;
        pulse_req();
        wait_err("t3_err_seen");
        repeat (5) @(negedge clk);
        chk("t3_tx_count", tx_log.size() - b, 32'd4);
        chk("t3_first_byte", {24'd0, log_at(b)}, 32'h32);
        chk("t3_last_byte", {24'd0, log_at(b + 3)}, 32'h35);
        chk("t3_no_fd", n_fd - f0, 32'd0);
        chk("t3_err_sticky", {31'd0, err}, 32'd1);
        chk("t3_busy_low", {31'd0, busy}, 32'd0);
        set_frame("xyC", 2, 0);
        pulse_req();
        chk("t3_err_cleared", {31'd0, err}, 32'd0);
        wait_fd(f0 + 1, "t3_recovery_frame");
        repeat (3) @(negedge clk);

        // Reset while waiting on the UART.
        set_frame("xyAB", 2, 0);
        t0 = n_tx;
        pulse_req();
        wait_tx(t0 + 1, "t4_first_tx_seen");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t4_reset_outputs", {18'd0, r_start, r_next, tx_start, busy, frame_done, err, tx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        t0 = n_tx; f0 = n_fd;
        repeat (60) @(negedge clk);
        chk("t4_no_tx_after_reset", n_tx - t0, 32'd0);
        chk("t4_no_fd_after_reset", n_fd - f0, 32'd0);
        chk("t4_busy_low", {31'd0, busy}, 32'd0);

        // Fast UART: next advance exactly two cycles after each send.
        fast = 1;
        set_frame("xyAB", 2, 0);
        b = tx_log.size(); f0 = n_fd; g0 = n_gap;
        pulse_req();
        wait_fd(f0 + 1, "t5_frame_done_seen");
        repeat (2) @(negedge clk);
        chk("t5_byte0", {24'd0, log_at(b)}, 32'h41);
        chk("t5_byte1", {24'd0, log_at(b + 1)}, 32'h42);
        chk("t5_gap_count", n_gap - g0, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
